// File: rtl/kbd_rx_fifo.sv
// Receive FIFO between the keyboard ASCII stage and the 8051: edge-detected writes,
// first-word fall-through read port, sticky overflow flag and level interrupt.
module kbd_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [7:0]    i_ascii,
  input  logic          i_key_received,
  input  logic          i_rd,
  input  logic          i_flush,
  input  logic          i_clr_ovf,
  input  logic          i_irq_en,
  output logic [7:0]    o_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  output logic          o_irq
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          key_q;
  logic          overflow;
  logic [7:0]    head;

  logic          wr_pulse;
  logic          is_full;
  logic          is_empty;
  logic          do_read;
  logic          do_write;
  logic          ovf_set;
  logic [AW-1:0] wr_next;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count_next;
  logic [7:0]    head_next;
  logic          overflow_next;

  assign is_full  = (count == FULL_COUNT);
  assign is_empty = (count == {(AW + 1){1'b0}});
  assign wr_pulse = i_key_received & ~key_q;
  assign do_read  = i_rd & ~is_empty & ~i_flush;
  assign do_write = wr_pulse & ~i_flush & (~is_full | do_read);
  assign ovf_set  = wr_pulse & is_full & ~do_read;

  // Next pointers, count, registered head entry and overflow flag.
  always_comb begin
    wr_next       = wr_ptr;
    rd_next       = rd_ptr;
    count_next    = count;
    head_next     = 8'h00;
    overflow_next = overflow;
    if (i_flush) begin
      wr_next    = {AW{1'b0}};
      rd_next    = {AW{1'b0}};
      count_next = {(AW + 1){1'b0}};
    end else begin
      if (do_write) begin
        wr_next = wr_ptr + AW'(1);
      end else begin
        wr_next = wr_ptr;
      end
      if (do_read) begin
        rd_next = rd_ptr + AW'(1);
      end else begin
        rd_next = rd_ptr;
      end
      case ({do_write, do_read})
        2'b10:   count_next = count + (AW + 1)'(1);
        2'b01:   count_next = count - (AW + 1)'(1);
        default: count_next = count;
      endcase
    end
    // The head must bypass storage when the slot it lands on is written this cycle.
    if (count_next == {(AW + 1){1'b0}}) begin
      head_next = 8'h00;
    end else if (do_write && (wr_ptr == rd_next)) begin
      head_next = i_ascii;
    end else begin
      head_next = mem[rd_next];
    end
    if (ovf_set) begin
      overflow_next = 1'b1;
    end else if (i_clr_ovf) begin
      overflow_next = 1'b0;
    end else begin
      overflow_next = overflow;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr   <= {AW{1'b0}};
      rd_ptr   <= {AW{1'b0}};
      count    <= {(AW + 1){1'b0}};
      key_q    <= 1'b0;
      overflow <= 1'b0;
      head     <= 8'h00;
    end else begin
      wr_ptr   <= wr_next;
      rd_ptr   <= rd_next;
      count    <= count_next;
      key_q    <= i_key_received;
      overflow <= overflow_next;
      head     <= head_next;
    end
  end

  // Character storage; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (do_write) begin
      mem[wr_ptr] <= i_ascii;
    end
  end

  assign o_data     = head;
  assign o_count    = count;
  assign o_empty    = is_empty;
  assign o_full     = is_full;
  assign o_overflow = overflow;
  assign o_irq      = i_irq_en & (~is_empty | overflow);

endmodule
